fsm_scheduler: RTL and testbench

Round-robin scheduler that shares the single five-state fetch/execute control FSM between `NREQ` requesters. It drives the core's `run`, `cont` and `halt` inputs and watches its `cs` state output. Each grant buys one burst of N instructions. Per-requester extended execution uses the EXECB phase. The block sits directly in front of the core FSM and is the only agent allowed to drive its control inputs.

---
 rtl/sched_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/fsm_scheduler.sv | 157 +++++++++++++++
 tb/tb_fsm_scheduler.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// -----------------------------------------------------------------------------
// sched_pkg
// Shared definitions for the fsm_scheduler slice:
//   - sched_state_t : scheduler states S_IDLE / S_START / S_RUN / S_DONE
//   - CS_*          : encodings of the core FSM state output `cs`
//   - cs_is_legal() : true for the five defined core states (000..100)
// -----------------------------------------------------------------------------
package sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } sched_state_t;

    localparam logic [2:0] CS_IDLE   = 3'b000;
    localparam logic [2:0] CS_FETCHA = 3'b001;
    localparam logic [2:0] CS_FETCHB = 3'b010;
    localparam logic [2:0] CS_EXECA  = 3'b011;
    localparam logic [2:0] CS_EXECB  = 3'b100;

    // Codes 101..111 are never produced by a healthy core.
    function automatic logic cs_is_legal(input logic [2:0] cs);
        return (cs <= CS_EXECB);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. Searches upward from i_last+1 with
// wrap-around and returns the first requester found as a one-hot vector.
// Ports:
//   i_req   [NREQ-1:0]         request levels
//   i_last  [$clog2(NREQ)-1:0] index of the previous winner (held by caller)
//   o_grant [NREQ-1:0]         one-hot winner (all zero when no request)
//   o_valid                    at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         i_req,
    input  logic [$clog2(NREQ)-1:0] i_last,
    output logic [NREQ-1:0]         o_grant,
    output logic                    o_valid
);

    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        // Offset 1 first so the previous winner is considered last.
        for (int k = 1; k <= NREQ; k++) begin
            if (!o_valid && i_req[(int'(i_last) + k) % NREQ]) begin
                o_grant[(int'(i_last) + k) % NREQ] = 1'b1;
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fsm_scheduler.sv
// -----------------------------------------------------------------------------
// fsm_scheduler
// Round-robin scheduler sharing one fetch/execute core FSM between NREQ
// requesters. Each grant buys one burst of max(burst_len,1) instructions.
// Optional feature macro: SCHED_ABORT_EN (adds i_abort, early burst abort).
// Ports:
//   i_clk, i_reset        clock / asynchronous active-high reset
//   i_req   [NREQ-1:0]    level request per requester
//   i_ext   [NREQ-1:0]    per-requester extended-execute enable
//   i_burst_len           instructions per burst, sampled at grant (0 -> 1)
//   i_cs    [2:0]         core state output
//   i_abort               (SCHED_ABORT_EN only) abort the running burst
//   o_grant [NREQ-1:0]    registered one-hot grant
//   o_run                 registered one-cycle start pulse to the core
//   o_cont, o_halt        core controls, combinational from i_cs + state
//   o_done  [NREQ-1:0]    burst-complete pulse to the granted requester
//   o_err                 abnormal-end pulse alongside o_done
//   o_busy                scheduler not in S_IDLE
// -----------------------------------------------------------------------------
module fsm_scheduler
    import sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int BURST_W = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NREQ-1:0]    i_req,
    input  logic [NREQ-1:0]    i_ext,
    input  logic [BURST_W-1:0] i_burst_len,
    input  logic [2:0]         i_cs,
`ifdef SCHED_ABORT_EN
    input  logic               i_abort,
`endif
    output logic [NREQ-1:0]    o_grant,
    output logic               o_run,
    output logic               o_cont,
    output logic               o_halt,
    output logic [NREQ-1:0]    o_done,
    output logic               o_err,
    output logic               o_busy
);

    localparam int LW = $clog2(NREQ);

    sched_state_t       r_state;
    logic [NREQ-1:0]    r_grant;
    logic               r_run;
    logic [NREQ-1:0]    r_done;
    logic               r_err;
    logic [LW-1:0]      r_last;
    logic [BURST_W-1:0] r_icount;
    logic [BURST_W-1:0] r_burst_q;
    logic               r_ext_q;
    logic               r_abort_q;

    logic [NREQ-1:0]    w_win;
    logic               w_valid;
    logic [LW-1:0]      w_win_idx;
    logic [BURST_W-1:0] w_burst;
    logic               w_execa;
    logic               w_last_instr;
    logic               w_core_bad;
    logic               w_abort_hit;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .i_req   (i_req),
        .i_last  (r_last),
        .o_grant (w_win),
        .o_valid (w_valid)
    );

    // One-hot winner back to an index for the round-robin pointer.
    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win[i]) w_win_idx = LW'(i);
        end
    end

    assign w_burst      = (i_burst_len == '0) ? BURST_W'(1) : i_burst_len;
    assign w_execa      = (r_state == S_RUN) && (i_cs == CS_EXECA);
    assign w_last_instr = (r_icount == (r_burst_q - BURST_W'(1)));
    // The core dropping back to IDLE (or reporting garbage) mid-burst means
    // the burst can no longer complete normally.
    assign w_core_bad   = (i_cs == CS_IDLE) || !cs_is_legal(i_cs);

`ifdef SCHED_ABORT_EN
    assign w_abort_hit  = i_abort && (r_state == S_RUN);
`else
    assign w_abort_hit  = 1'b0;
`endif

    // Final instruction (by count or pending abort) halts and never extends.
    assign o_halt  = w_execa && (w_last_instr || r_abort_q);
    assign o_cont  = w_execa && !o_halt && r_ext_q;
    assign o_grant = r_grant;
    assign o_run   = r_run;
    assign o_done  = r_done;
    assign o_err   = r_err;
    assign o_busy  = (r_state != S_IDLE);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_run     <= 1'b0;
            r_done    <= '0;
            r_err     <= 1'b0;
            r_last    <= LW'(NREQ - 1);
            r_icount  <= '0;
            r_burst_q <= BURST_W'(1);
            r_ext_q   <= 1'b0;
            r_abort_q <= 1'b0;
        end else begin
            r_run  <= 1'b0;
            r_done <= '0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_abort_q <= 1'b0;
                    if (w_valid) begin
                        r_grant   <= w_win;
                        r_last    <= w_win_idx;
                        r_burst_q <= w_burst;
                        r_ext_q   <= |(i_ext & w_win);
                        r_icount  <= '0;
                        r_run     <= 1'b1;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_abort_hit) r_abort_q <= 1'b1;
                    if (w_execa) r_icount <= r_icount + BURST_W'(1);
                    if (o_halt) begin
                        r_done  <= r_grant;
                        r_err   <= r_abort_q;
                        r_state <= S_DONE;
                    end else if (w_core_bad) begin
                        r_done  <= r_grant;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_grant <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fsm_scheduler
// Self-checking bench for fsm_scheduler. A behavioural core FSM closes the
// loop on run/cont/halt -> cs. Expected waveforms come from an arithmetic
// model: winner by round-robin search, EXECA cycles at 4, +3(+1 if extended),
// halt on the last EXECA, done one cycle later, then one idle cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fsm_scheduler;

    localparam int NREQ = 4;
    localparam int BW   = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] ext = '0;
    logic [BW-1:0]   burst_len = '0;
    logic [2:0]      cs;
    logic [NREQ-1:0] grant, done;
    logic            run, cont, halt, err, busy;
    logic            core_kill = 1'b0;
`ifdef SCHED_ABORT_EN
    logic            abort = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int model_last = NREQ - 1;

    always #5 clk = ~clk;

    fsm_scheduler #(.NREQ(NREQ), .BURST_W(BW)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_req       (req),
        .i_ext       (ext),
        .i_burst_len (burst_len),
        .i_cs        (cs),
`ifdef SCHED_ABORT_EN
        .i_abort     (abort),
`endif
        .o_grant     (grant),
        .o_run       (run),
        .o_cont      (cont),
        .o_halt      (halt),
        .o_done      (done),
        .o_err       (err),
        .o_busy      (busy)
    );

    // Behavioural core: IDLE=0 FETCHA=1 FETCHB=2 EXECA=3 EXECB=4.
    // Shares the reset; core_kill models the core collapsing to IDLE.
    always @(posedge clk or posedge reset) begin
        if (reset) cs <= 3'd0;
        else if (core_kill) cs <= 3'd0;
        else begin
            case (cs)
                3'd0: if (run) cs <= 3'd1;
                3'd1: cs <= 3'd2;
                3'd2: cs <= 3'd3;
                3'd3: cs <= halt ? 3'd0 : (cont ? 3'd4 : 3'd1);
                3'd4: cs <= 3'd1;
                default: cs <= 3'd0;
            endcase
        end
    end

    function automatic logic [12:0] pack(input logic [NREQ-1:0] g, input logic r, input logic c,
                                         input logic h, input logic [NREQ-1:0] d,
                                         input logic e, input logic b);
        return {g, r, c, h, d, e, b};
    endfunction

    function automatic logic [12:0] observed();
        return {grant, run, cont, halt, done, err, busy};
    endfunction

    // One granted burst from cycle 0 (caller is #1 after an edge) through the
    // idle cycle after done. Inputs are scrambled mid-burst to confirm they
    // are ignored once granted.
    task automatic do_burst(input logic [NREQ-1:0] rq, input logic [BW-1:0] len,
                            input logic [NREQ-1:0] ex, input string tag);
        int win, n, e, d, t;
        int execa[$];
        logic [NREQ-1:0] g;
        logic [12:0] exp_v;
        logic exp_cont;
        req = rq; burst_len = len; ext = ex;
        win = -1;
        for (int k = 1; k <= NREQ; k++)
            if (win < 0 && rq[(model_last + k) % NREQ]) win = (model_last + k) % NREQ;
        if (win < 0) begin
            req = '0;
            return;
        end
        model_last = win;
        g = '0; g[win] = 1'b1;
        n = (len == 0) ? 1 : int'(len);
        e = int'(ex[win]);
        t = 4;
        for (int i = 0; i < n; i++) begin
            execa.push_back(t);
            t += 3 + e;
        end
        d = execa[n-1] + 1;
        for (int c = 1; c <= d + 1; c++) begin
            @(posedge clk); #1;
            exp_cont = 1'b0;
            for (int i = 0; i < n - 1; i++)
                if (execa[i] == c && e == 1) exp_cont = 1'b1;
            exp_v = pack((c <= d) ? g : '0, c == 1, exp_cont, c == execa[n-1],
                         (c == d) ? g : '0, 1'b0, c <= d);
            checks++;
            if (observed() !== exp_v) begin
                failures++;
                $display("FAIL %s cyc=%0d {grant,run,cont,halt,done,err,busy} got=%b exp=%b",
                         tag, c, observed(), exp_v);
            end
            if (c >= 2 && c <= d) begin
                ext = NREQ'($urandom);
                burst_len = BW'($urandom);
                req = NREQ'($urandom);
            end
        end
        req = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; core_kill = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (observed() !== 13'd0) begin
            failures++;
            $display("FAIL reset outputs got=%b exp=%b", observed(), 13'd0);
        end
        reset = 1'b0;
        model_last = NREQ - 1;
    endtask

    // Steps one cycle and compares against an explicit expected vector.
    task automatic step_check(input logic [12:0] exp_v, input string tag, input int c);
        @(posedge clk); #1;
        checks++;
        if (observed() !== exp_v) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", tag, c, observed(), exp_v);
        end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_single();
        do_burst(4'b0001, 4'd1, 4'b0000, "single");
    endtask

    task automatic test_ext();
        do_burst(4'b0010, 4'd3, 4'b0010, "ext");
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 5; i++) do_burst(4'b1111, 4'd1, 4'b0000, "b2b");
    endtask

    task automatic test_len_zero();
        do_burst(4'b0100, 4'd0, 4'b0100, "len0");
        do_burst(4'b1000, 4'd0, 4'b0000, "len0");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++)
            do_burst(NREQ'($urandom_range(1, 15)), BW'($urandom_range(0, 15)),
                     NREQ'($urandom), "random");
    endtask

    task automatic test_core_error();
        logic [NREQ-1:0] g = 4'b0001;
        do_reset();
        req = 4'b0001; burst_len = 4'd4; ext = 4'b0000;
        step_check(pack(g, 1, 0, 0, 0, 0, 1), "core_err", 1);
        req = '0;
        step_check(pack(g, 0, 0, 0, 0, 0, 1), "core_err", 2);
        step_check(pack(g, 0, 0, 0, 0, 0, 1), "core_err", 3);
        core_kill = 1'b1;
        step_check(pack(g, 0, 0, 0, 0, 0, 1), "core_err", 4);
        core_kill = 1'b0;
        step_check(pack(g, 0, 0, 0, g, 1, 1), "core_err", 5);
        step_check(pack('0, 0, 0, 0, 0, 0, 0), "core_err", 6);
        model_last = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0010; burst_len = 4'd3; ext = 4'b0000;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            req = '0;
        end
        reset = 1'b1;
        #1;
        checks++;
        if (observed() !== 13'd0) begin
            failures++;
            $display("FAIL reset_mid outputs got=%b exp=%b", observed(), 13'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        model_last = NREQ - 1;
        // With the pointer back at NREQ-1, requester 1 beats requester 2.
        do_burst(4'b0110, 4'd2, 4'b0000, "post_reset");
        do_reset();
        do_burst(4'b0100, 4'd3, 4'b0000, "post_reset");
    endtask

`ifdef SCHED_ABORT_EN
    task automatic test_abort();
        logic [NREQ-1:0] g = 4'b0001;
        do_reset();
        req = 4'b0001; burst_len = 4'd4; ext = 4'b0001;
        step_check(pack(g, 1, 0, 0, 0, 0, 1), "abort", 1);
        req = '0;
        step_check(pack(g, 0, 0, 0, 0, 0, 1), "abort", 2);
        abort = 1'b1;
        step_check(pack(g, 0, 0, 0, 0, 0, 1), "abort", 3);
        abort = 1'b0;
        step_check(pack(g, 0, 0, 1, 0, 0, 1), "abort", 4);
        step_check(pack(g, 0, 0, 0, g, 1, 1), "abort", 5);
        step_check(pack('0, 0, 0, 0, 0, 0, 0), "abort", 6);
        model_last = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_ext();
        test_back_to_back();
        test_len_zero();
        test_random();
        test_core_error();
        test_reset_mid();
`ifdef SCHED_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
